// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
//    Shared types and defaults for the 2-stage fetch/EX/WB cpu pipeline
//    control blocks.
//
//    Contents:
//       PC_W_DEF     default width of the word-addressed fetch PC
//       seq_state_t  pc_sequencer FSM state encoding
//       seq_active   true in the states that fetch and execute (RUN, STALL)
// ---------------------------------------------------------------------------
package cpu_pkg;

   localparam int unsigned PC_W_DEF = 12;

   typedef enum logic [1:0] {
      SEQ_RUN   = 2'd0,
      SEQ_STALL = 2'd1,
      SEQ_HALT  = 2'd2
   } seq_state_t;

   // RUN and STALL both carry a live EX instruction; HALT carries none.
   function automatic logic seq_active(input seq_state_t s);
      return (s == SEQ_RUN) || (s == SEQ_STALL);
   endfunction

endpackage

// File: rtl/stall_watchdog.sv
// ---------------------------------------------------------------------------
// stall_watchdog
//    Bounds how long the EX stage may be held. Counts consecutive held
//    cycles and raises timeout_now on the cycle that would be the
//    STALL_MAX-th held cycle, so the sequencer releases the instruction
//    instead of holding it again. A registered one-cycle stall_timeout
//    pulse follows every forced release. STALL_MAX = 0 disables the
//    watchdog entirely.
//
//    Ports:
//       clck           in   clock, rising edge
//       rst_n          in   asynchronous active-low reset
//       in_stall       in   sequencer is currently in the STALL state
//       hold           in   EX is held this cycle (ex_hold)
//       timeout_now    out  combinational: force release this cycle
//       stall_timeout  out  registered pulse, one cycle after forced release
// ---------------------------------------------------------------------------
module stall_watchdog #(
   parameter int unsigned STALL_MAX = 255
) (
   input  logic clck,
   input  logic rst_n,
   input  logic in_stall,
   input  logic hold,
   output logic timeout_now,
   output logic stall_timeout
);

   // Counter wide enough to hold STALL_MAX; one bit minimum when disabled.
   localparam int unsigned CNT_W = (STALL_MAX < 2) ? 1 : $clog2(STALL_MAX + 1);
   localparam logic [CNT_W-1:0] CNT_LIMIT =
      (STALL_MAX == 0) ? '0 : CNT_W'(STALL_MAX - 1);
   localparam logic [CNT_W-1:0] CNT_SAT = '1;

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             stall_timeout_q, stall_timeout_d;

   // The count only grows while held; any non-held cycle (release, halt,
   // plain RUN) returns it to zero, so a new stall always starts fresh.
   // Saturation keeps a disabled watchdog from wrapping back to zero.
   always_comb begin
      timeout_now     = (STALL_MAX != 0) && in_stall && (cnt_q == CNT_LIMIT);
      cnt_d           = '0;
      if (hold) begin
         cnt_d = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + 1'b1;
      end
      stall_timeout_d = timeout_now;
   end

   always_ff @(posedge clck or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q           <= '0;
         stall_timeout_q <= 1'b0;
      end else begin
         cnt_q           <= cnt_d;
         stall_timeout_q <= stall_timeout_d;
      end
   end

   assign stall_timeout = stall_timeout_q;

endmodule

// File: rtl/pc_sequencer.sv
// ---------------------------------------------------------------------------
// pc_sequencer
//    Owns the fetch PC and the EX-stage valid bit of the 2-stage
//    fetch/EX/WB pipeline. Sequences fetch through taken redirects,
//    multi-cycle EX stalls (bounded by stall_watchdog) and halt/resume,
//    and counts retired instructions.
//
//    Ports:
//       clck                in   clock, rising edge
//       rst_n               in   asynchronous active-low reset
//       redirect_valid_ex   in   EX instruction is a taken branch/jump
//       redirect_target_ex  in   redirect word address
//       stall_req_ex        in   EX instruction cannot complete this cycle
//       halt_req_ex         in   EX instruction is a halt
//       resume              in   leave HALT
//       pc_fetch            out  inst_ram read address
//       pc_ex               out  address of the instruction in EX
//       fetch_en            out  load instruction_EX this edge
//       ex_valid            out  instruction_EX is architectural
//       ex_hold             out  hold instruction_EX, suppress its writeback
//       halted              out  sequencer is in HALT
//       stall_timeout       out  one-cycle pulse after a forced release
//       retire_count        out  retired instructions, wraps mod 2**32
// ---------------------------------------------------------------------------
module pc_sequencer
   import cpu_pkg::*;
#(
   parameter int unsigned      PC_W      = PC_W_DEF,
   parameter logic [PC_W-1:0]  RESET_PC  = '0,
   parameter int unsigned      STALL_MAX = 255
) (
   input  logic            clck,
   input  logic            rst_n,
   input  logic            redirect_valid_ex,
   input  logic [PC_W-1:0] redirect_target_ex,
   input  logic            stall_req_ex,
   input  logic            halt_req_ex,
   input  logic            resume,
   output logic [PC_W-1:0] pc_fetch,
   output logic [PC_W-1:0] pc_ex,
   output logic            fetch_en,
   output logic            ex_valid,
   output logic            ex_hold,
   output logic            halted,
   output logic            stall_timeout,
   output logic [31:0]     retire_count
);

   seq_state_t      state_q, state_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic            ex_valid_q, ex_valid_d;
   logic [31:0]     retire_q, retire_d;

   logic active;
   logic halt_take;
   logic redirect_take;
   logic retire;
   logic timeout_now;

   stall_watchdog #(
      .STALL_MAX (STALL_MAX)
   ) u_watchdog (
      .clck          (clck),
      .rst_n         (rst_n),
      .in_stall      (state_q == SEQ_STALL),
      .hold          (ex_hold),
      .timeout_now   (timeout_now),
      .stall_timeout (stall_timeout)
   );

   // Pipeline control decode. Requests only count when the EX instruction
   // is architectural; a killed bubble cannot stall, halt or redirect.
   // Halt outranks stall, and a watchdog timeout turns a stall into a
   // normal completion. A redirect is taken only when fetch actually
   // proceeds, so a redirect seen during a hold waits for the release.
   always_comb begin
      active        = seq_active(state_q);
      halt_take     = active && ex_valid_q && halt_req_ex;
      ex_hold       = active && ex_valid_q && stall_req_ex &&
                      !halt_req_ex && !timeout_now;
      fetch_en      = active && !ex_hold && !(ex_valid_q && halt_req_ex);
      redirect_take = fetch_en && ex_valid_q && redirect_valid_ex;
      retire        = active && ex_valid_q && !ex_hold;
   end

   // Next-state, PC and EX-valid update. The PC stays one ahead of the EX
   // instruction: on a redirect the word fetched this edge is from the
   // wrong path, so it is marked invalid, giving exactly one bubble.
   // Halting keeps pc_fetch on the word after the halt so resume simply
   // restarts fetch from there.
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      ex_valid_d = ex_valid_q;
      retire_d   = retire ? retire_q + 32'd1 : retire_q;

      unique case (state_q)
         SEQ_RUN, SEQ_STALL: begin
            if (halt_take) begin
               state_d    = SEQ_HALT;
               ex_valid_d = 1'b0;
            end else if (ex_hold) begin
               state_d    = SEQ_STALL;
            end else begin
               state_d = SEQ_RUN;
               if (redirect_take) begin
                  pc_d       = redirect_target_ex;
                  ex_valid_d = 1'b0;
               end else begin
                  pc_d       = pc_q + PC_W'(1);
                  ex_valid_d = 1'b1;
               end
            end
         end
         SEQ_HALT: begin
            ex_valid_d = 1'b0;
            if (resume) begin
               state_d = SEQ_RUN;
            end
         end
         default: begin
            state_d    = SEQ_RUN;
            ex_valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clck or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= SEQ_RUN;
         pc_q       <= RESET_PC;
         ex_valid_q <= 1'b0;
         retire_q   <= '0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         ex_valid_q <= ex_valid_d;
         retire_q   <= retire_d;
      end
   end

   assign pc_fetch     = pc_q;
   assign pc_ex        = pc_q - PC_W'(1);
   assign ex_valid     = ex_valid_q;
   assign halted       = (state_q == SEQ_HALT);
   assign retire_count = retire_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pc_sequencer
//    Directed bench for pc_sequencer. Two instances share all inputs:
//    dut (watchdog at 255, effectively idle here) and dutWd (watchdog at 4).
//    Both use an 11-bit PC so the 0x7FF -> 0x000 wrap can be exercised.
// ---------------------------------------------------------------------------
module tb_pc_sequencer;

   localparam int unsigned PC_W = 11;

   logic            clck;
   logic            rst_n;
   logic            redirect_valid_ex;
   logic [PC_W-1:0] redirect_target_ex;
   logic            stall_req_ex;
   logic            halt_req_ex;
   logic            resume;

   logic [PC_W-1:0] pc_fetch, pc_ex;
   logic            fetch_en, ex_valid, ex_hold, halted, stall_timeout;
   logic [31:0]     retire_count;

   logic [PC_W-1:0] pc_fetch_w, pc_ex_w;
   logic            fetch_en_w, ex_valid_w, ex_hold_w, halted_w, stall_timeout_w;
   logic [31:0]     retire_count_w;

   int vectorCount = 0;
   int missCount   = 0;

   pc_sequencer #(.PC_W(PC_W), .RESET_PC('0), .STALL_MAX(255)) dut (
      .clck               (clck),
      .rst_n              (rst_n),
      .redirect_valid_ex  (redirect_valid_ex),
      .redirect_target_ex (redirect_target_ex),
      .stall_req_ex       (stall_req_ex),
      .halt_req_ex        (halt_req_ex),
      .resume             (resume),
      .pc_fetch           (pc_fetch),
      .pc_ex              (pc_ex),
      .fetch_en           (fetch_en),
      .ex_valid           (ex_valid),
      .ex_hold            (ex_hold),
      .halted             (halted),
      .stall_timeout      (stall_timeout),
      .retire_count       (retire_count)
   );

   pc_sequencer #(.PC_W(PC_W), .RESET_PC('0), .STALL_MAX(4)) dutWd (
      .clck               (clck),
      .rst_n              (rst_n),
      .redirect_valid_ex  (redirect_valid_ex),
      .redirect_target_ex (redirect_target_ex),
      .stall_req_ex       (stall_req_ex),
      .halt_req_ex        (halt_req_ex),
      .resume             (resume),
      .pc_fetch           (pc_fetch_w),
      .pc_ex              (pc_ex_w),
      .fetch_en           (fetch_en_w),
      .ex_valid           (ex_valid_w),
      .ex_hold            (ex_hold_w),
      .halted             (halted_w),
      .stall_timeout      (stall_timeout_w),
      .retire_count       (retire_count_w)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial clck = 1'b0;
   always #5 clck = ~clck;

   // Single comparison point: counts and reports every check.
   task automatic checkOutput(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
      vectorCount++;
      if (actual !== expected) begin
         missCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   // Drive all request inputs, then let combinational outputs settle.
   task automatic applyStimulus(input logic rv, input logic [PC_W-1:0] tgt,
                                input logic st, input logic ht, input logic rs);
      redirect_valid_ex  = rv;
      redirect_target_ex = tgt;
      stall_req_ex       = st;
      halt_req_ex        = ht;
      resume             = rs;
      #1;
   endtask

   // Asynchronous reset between clock edges, check reset values on both
   // instances, then release on a falling edge.
   task automatic doReset(input string tag);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput({tag, "_pc"},     32'(pc_fetch),        32'h000);
      checkOutput({tag, "_pcex"},   32'(pc_ex),           32'h7FF);
      checkOutput({tag, "_exv"},    32'(ex_valid),        0);
      checkOutput({tag, "_fen"},    32'(fetch_en),        1);
      checkOutput({tag, "_hold"},   32'(ex_hold),         0);
      checkOutput({tag, "_halted"}, 32'(halted),          0);
      checkOutput({tag, "_tmo"},    32'(stall_timeout),   0);
      checkOutput({tag, "_ret"},    retire_count,         0);
      checkOutput({tag, "_pc_w"},   32'(pc_fetch_w),      32'h000);
      checkOutput({tag, "_halt_w"}, 32'(halted_w),        0);
      checkOutput({tag, "_ret_w"},  retire_count_w,       0);
      applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
      @(negedge clck);
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b1;
      redirect_valid_ex  = 1'b0;
      redirect_target_ex = '0;
      stall_req_ex       = 1'b0;
      halt_req_ex        = 1'b0;
      resume             = 1'b0;

      // Test 1: free run from reset
      doReset("rst0");
      for (int i = 0; i < 6; i++) begin
         checkOutput("t1_pc",  32'(pc_fetch), i);
         checkOutput("t1_exv", 32'(ex_valid), (i != 0) ? 1 : 0);
         checkOutput("t1_ret", retire_count, (i > 1) ? i - 1 : 0);
         if (i < 5) @(negedge clck);
      end

      // Test 2: redirect to 0x040 from pc_ex 0x003, one bubble
      doReset("rst1");
      repeat (4) @(negedge clck);
      checkOutput("t2_pcex0", 32'(pc_ex), 32'h003);
      checkOutput("t2_exv0",  32'(ex_valid), 1);
      checkOutput("t2_ret0",  retire_count, 3);
      applyStimulus(1'b1, 11'h040, 1'b0, 1'b0, 1'b0);
      checkOutput("t2_fen0", 32'(fetch_en), 1);
      @(negedge clck);
      checkOutput("t2_pc1",  32'(pc_fetch), 32'h040);
      checkOutput("t2_exv1", 32'(ex_valid), 0);
      checkOutput("t2_ret1", retire_count, 4);
      // redirect on a bubble must be ignored
      applyStimulus(1'b1, 11'h100, 1'b0, 1'b0, 1'b0);
      @(negedge clck);
      checkOutput("t2_pc2",   32'(pc_fetch), 32'h041);
      checkOutput("t2_pcex2", 32'(pc_ex), 32'h040);
      checkOutput("t2_exv2",  32'(ex_valid), 1);
      checkOutput("t2_ret2",  retire_count, 4);

      // Test 3: 3-cycle stall at pc_ex 0x010 with redirect held high
      applyStimulus(1'b1, 11'h010, 1'b0, 1'b0, 1'b0);
      @(negedge clck);
      applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
      @(negedge clck);
      checkOutput("t3_pcex", 32'(pc_ex), 32'h010);
      checkOutput("t3_ret0", retire_count, 5);
      applyStimulus(1'b1, 11'h060, 1'b1, 1'b0, 1'b0);
      checkOutput("t3_hold0", 32'(ex_hold), 1);
      checkOutput("t3_fen0",  32'(fetch_en), 0);
      for (int k = 1; k < 3; k++) begin
         @(negedge clck);
         checkOutput("t3_pc_h",   32'(pc_fetch), 32'h011);
         checkOutput("t3_ret_h",  retire_count, 5);
         checkOutput("t3_hold_h", 32'(ex_hold), 1);
      end
      @(negedge clck);
      checkOutput("t3_pc_r", 32'(pc_fetch), 32'h011);
      applyStimulus(1'b1, 11'h060, 1'b0, 1'b0, 1'b0);
      checkOutput("t3_hold_r", 32'(ex_hold), 0);
      checkOutput("t3_fen_r",  32'(fetch_en), 1);
      @(negedge clck);
      applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
      checkOutput("t3_pc_t",  32'(pc_fetch), 32'h060);
      checkOutput("t3_exv_t", 32'(ex_valid), 0);
      checkOutput("t3_ret_t", retire_count, 6);

      // Test 4: watchdog forced release (dutWd, STALL_MAX = 4)
      doReset("rst2");
      @(negedge clck);
      checkOutput("t4_pc1", 32'(pc_fetch_w), 32'h001);
      applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
      checkOutput("t4_hold1", 32'(ex_hold_w), 1);
      @(negedge clck);
      checkOutput("t4_hold2", 32'(ex_hold_w), 1);
      @(negedge clck);
      checkOutput("t4_hold3", 32'(ex_hold_w), 1);
      checkOutput("t4_ret3",  retire_count_w, 0);
      @(negedge clck);
      checkOutput("t4_hold4",  32'(ex_hold_w), 0);
      checkOutput("t4_fen4",   32'(fetch_en_w), 1);
      checkOutput("t4_tmo4",   32'(stall_timeout_w), 0);
      checkOutput("t4_ret4",   retire_count_w, 0);
      checkOutput("t4_big4",   32'(ex_hold), 1);
      @(negedge clck);
      checkOutput("t4_tmo5",   32'(stall_timeout_w), 1);
      checkOutput("t4_pc5",    32'(pc_fetch_w), 32'h002);
      checkOutput("t4_ret5",   retire_count_w, 1);
      checkOutput("t4_hold5",  32'(ex_hold_w), 1);
      checkOutput("t4_bigpc5", 32'(pc_fetch), 32'h001);
      checkOutput("t4_bigtmo", 32'(stall_timeout), 0);
      @(negedge clck);
      checkOutput("t4_tmo6", 32'(stall_timeout_w), 0);
      applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);

      // Test 5: halt at pc_ex 0x020 with redirect and stall, then resume
      doReset("rst3");
      @(negedge clck);
      applyStimulus(1'b1, 11'h020, 1'b0, 1'b0, 1'b0);
      @(negedge clck);
      applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
      @(negedge clck);
      checkOutput("t5_pcex0", 32'(pc_ex), 32'h020);
      checkOutput("t5_ret0",  retire_count, 1);
      applyStimulus(1'b1, 11'h300, 1'b1, 1'b1, 1'b0);
      checkOutput("t5_fen0",  32'(fetch_en), 0);
      checkOutput("t5_hold0", 32'(ex_hold), 0);
      @(negedge clck);
      applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
      checkOutput("t5_halted1", 32'(halted), 1);
      checkOutput("t5_pc1",     32'(pc_fetch), 32'h021);
      checkOutput("t5_exv1",    32'(ex_valid), 0);
      checkOutput("t5_fen1",    32'(fetch_en), 0);
      checkOutput("t5_ret1",    retire_count, 2);
      @(negedge clck);
      checkOutput("t5_halted2", 32'(halted), 1);
      applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1);
      checkOutput("t5_fen2", 32'(fetch_en), 0);
      @(negedge clck);
      applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
      checkOutput("t5_halted3", 32'(halted), 0);
      checkOutput("t5_pc3",     32'(pc_fetch), 32'h021);
      checkOutput("t5_fen3",    32'(fetch_en), 1);
      @(negedge clck);
      checkOutput("t5_pcex4", 32'(pc_ex), 32'h021);
      checkOutput("t5_exv4",  32'(ex_valid), 1);
      checkOutput("t5_ret4",  retire_count, 2);

      // Test 6: reset mid-HALT, reset mid-STALL, PC wrap
      applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b0);
      @(negedge clck);
      applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
      checkOutput("t6_halted", 32'(halted), 1);
      doReset("rst_halt");
      @(negedge clck);
      applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
      @(negedge clck);
      checkOutput("t6_hold", 32'(ex_hold), 1);
      doReset("rst_stall");
      @(negedge clck);
      applyStimulus(1'b1, 11'h7FF, 1'b0, 1'b0, 1'b0);
      @(negedge clck);
      applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
      checkOutput("t6_pc_top", 32'(pc_fetch), 32'h7FF);
      @(negedge clck);
      checkOutput("t6_pc_wrap", 32'(pc_fetch), 32'h000);
      checkOutput("t6_pcex",    32'(pc_ex), 32'h7FF);
      checkOutput("t6_exv",     32'(ex_valid), 1);
      @(negedge clck);
      checkOutput("t6_pc_next", 32'(pc_fetch), 32'h001);

      $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
      $finish;
   end

endmodule
